// File: rtl/idct_pkg.sv
// Shared types and constants for the 8x8 inverse DCT core.
package idct_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ROWS = 2'd1,
        COLS = 2'd2,
        OUT  = 2'd3
    } idct_state_t;

    localparam int COS_FRAC   = 8;
    localparam int ROUND_BIAS = 128;
    localparam int BLK_N      = 8;
    localparam int BLK_SZ     = 64;

    // Output clamp limits: two's complement pixels, or level-shifted unsigned pixels.
    localparam int PIX_MIN_SIGNED   = -128;
    localparam int PIX_MAX_SIGNED   = 127;
    localparam int PIX_MIN_UNSIGNED = 0;
    localparam int PIX_MAX_UNSIGNED = 255;
    localparam int LEVEL_SHIFT      = 128;

endpackage

// File: rtl/idct_cos_lut.sv
// Q.8 cosine basis C[k][n] = round(256 * a(k) * cos((2n+1)k*pi/16)).
// The angle index j = (2n+1)k is folded onto the first quadrant so only
// nine magnitudes need storing; row k=0 is the constant 91.
module idct_cos_lut
    import idct_pkg::*;
(
    input  logic [2:0]        k,
    input  logic [2:0]        n,
    output logic signed [9:0] c
);

    logic [6:0]        prod_s;
    logic [5:0]        jf_s;
    logic [3:0]        q_s;
    logic              neg_s;
    logic signed [9:0] mag_s;

    // Fold the angle index and look up the magnitude.
    always_comb begin
        prod_s = {3'b000, n, 1'b1} * {4'b0000, k};
        if (prod_s[4:0] > 5'd16) begin
            jf_s = 6'd32 - {1'b0, prod_s[4:0]};
        end else begin
            jf_s = {1'b0, prod_s[4:0]};
        end
        if (jf_s > 6'd8) begin
            neg_s = 1'b1;
            q_s   = 4'(6'd16 - jf_s);
        end else begin
            neg_s = 1'b0;
            q_s   = jf_s[3:0];
        end
        case (q_s)
            4'd0:    mag_s = 10'sd128;
            4'd1:    mag_s = 10'sd126;
            4'd2:    mag_s = 10'sd118;
            4'd3:    mag_s = 10'sd106;
            4'd4:    mag_s = 10'sd91;
            4'd5:    mag_s = 10'sd71;
            4'd6:    mag_s = 10'sd49;
            4'd7:    mag_s = 10'sd25;
            4'd8:    mag_s = 10'sd0;
            default: mag_s = 10'sd0;
        endcase
        if (k == 3'd0) begin
            c = 10'sd91;
        end else if (neg_s) begin
            c = -mag_s;
        end else begin
            c = mag_s;
        end
    end

endmodule

// File: rtl/idct_8x8_core.sv
// Sequential 8x8 inverse DCT: load 64 coefficients, row pass, column pass,
// then stream 64 pixels. One shared multiply-accumulate serves both passes.
// Optional feature macro IDCT_LEVEL_SHIFT_EN: output y+128 clamped to [0,255]
// instead of y clamped to [-128,127].
module idct_8x8_core
    import idct_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int TMP_W  = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [COEF_W-1:0] coef_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_data,
    output logic              busy
);

    localparam logic signed [ACC_W-1:0] BIAS_C    = ACC_W'(ROUND_BIAS);
    localparam logic signed [ACC_W-1:0] TMP_MAX_C = ACC_W'((1 <<< (TMP_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] TMP_MIN_C = ACC_W'(-(1 <<< (TMP_W - 1)));
`ifdef IDCT_LEVEL_SHIFT_EN
    localparam logic signed [ACC_W-1:0] SHIFT_C   = ACC_W'(LEVEL_SHIFT);
    localparam logic signed [ACC_W-1:0] PIX_LO_C  = ACC_W'(PIX_MIN_UNSIGNED);
    localparam logic signed [ACC_W-1:0] PIX_HI_C  = ACC_W'(PIX_MAX_UNSIGNED);
`else
    localparam logic signed [ACC_W-1:0] SHIFT_C   = ACC_W'(0);
    localparam logic signed [ACC_W-1:0] PIX_LO_C  = ACC_W'(PIX_MIN_SIGNED);
    localparam logic signed [ACC_W-1:0] PIX_HI_C  = ACC_W'(PIX_MAX_SIGNED);
`endif
    localparam logic [5:0] IDX_LAST_C = 6'(BLK_SZ - 1);
    localparam logic [2:0] M_LAST_C   = 3'(BLK_N - 1);

    idct_state_t state_r, state_nx_s;
    logic [5:0]  idx_r, idx_nx_s;
    logic [2:0]  m_r, m_nx_s;
    logic signed [ACC_W-1:0] acc_r, acc_nx_s;
    logic        coef_ready_r, pix_valid_r, busy_r;
    logic [7:0]  pix_data_r;
    logic        cbuf_we_s, tbuf_we_s, pbuf_we_s;

    logic signed [COEF_W-1:0] cbuf_r [BLK_SZ];
    logic signed [TMP_W-1:0]  tbuf_r [BLK_SZ];
    logic [7:0]               pbuf_r [BLK_SZ];

    logic [2:0]              lut_n_s;
    logic signed [9:0]       lut_c_s;
    logic signed [TMP_W-1:0] opa_s;
    logic signed [ACC_W-1:0] prod_s, sum_s, rnd_s, pix_full_s;
    logic signed [TMP_W-1:0] tmp_sat_s;
    logic [7:0]              pix_s;

    idct_cos_lut u_cos_lut (
        .k (m_r),
        .n (lut_n_s),
        .c (lut_c_s)
    );

    // Operand selection, product, rounding and the two saturation paths.
    always_comb begin
        if (state_r == COLS) begin
            lut_n_s = idx_r[5:3];
            opa_s   = tbuf_r[{m_r, idx_r[2:0]}];
        end else begin
            lut_n_s = idx_r[2:0];
            opa_s   = {{(TMP_W-COEF_W){cbuf_r[{idx_r[5:3], m_r}][COEF_W-1]}},
                       cbuf_r[{idx_r[5:3], m_r}]};
        end
        prod_s = {{(ACC_W-TMP_W){opa_s[TMP_W-1]}}, opa_s} * {{(ACC_W-10){lut_c_s[9]}}, lut_c_s};
        sum_s  = acc_r + prod_s;
        rnd_s  = (sum_s + BIAS_C) >>> COS_FRAC;
        if (rnd_s > TMP_MAX_C) begin
            tmp_sat_s = TMP_MAX_C[TMP_W-1:0];
        end else if (rnd_s < TMP_MIN_C) begin
            tmp_sat_s = TMP_MIN_C[TMP_W-1:0];
        end else begin
            tmp_sat_s = rnd_s[TMP_W-1:0];
        end
        pix_full_s = rnd_s + SHIFT_C;
        if (pix_full_s > PIX_HI_C) begin
            pix_s = PIX_HI_C[7:0];
        end else if (pix_full_s < PIX_LO_C) begin
            pix_s = PIX_LO_C[7:0];
        end else begin
            pix_s = pix_full_s[7:0];
        end
    end

    // Next-state, index/tap counters, accumulator and buffer write enables.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        m_nx_s     = m_r;
        acc_nx_s   = acc_r;
        cbuf_we_s  = 1'b0;
        tbuf_we_s  = 1'b0;
        pbuf_we_s  = 1'b0;
        case (state_r)
            LOAD: begin
                m_nx_s   = 3'd0;
                acc_nx_s = '0;
                if (coef_valid && coef_ready_r) begin
                    cbuf_we_s = 1'b1;
                    idx_nx_s  = idx_r + 6'd1;
                    if (idx_r == IDX_LAST_C) begin
                        state_nx_s = ROWS;
                    end else begin
                        state_nx_s = LOAD;
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            ROWS, COLS: begin
                m_nx_s = m_r + 3'd1;
                if (m_r == M_LAST_C) begin
                    tbuf_we_s = (state_r == ROWS);
                    pbuf_we_s = (state_r == COLS);
                    acc_nx_s  = '0;
                    idx_nx_s  = idx_r + 6'd1;
                    if (idx_r == IDX_LAST_C) begin
                        state_nx_s = (state_r == ROWS) ? COLS : OUT;
                    end else begin
                        state_nx_s = state_r;
                    end
                end else begin
                    acc_nx_s = sum_s;
                end
            end
            OUT: begin
                if (pix_valid_r && pix_ready) begin
                    idx_nx_s = idx_r + 6'd1;
                    if (idx_r == IDX_LAST_C) begin
                        state_nx_s = LOAD;
                    end else begin
                        state_nx_s = OUT;
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            default: begin
                state_nx_s = LOAD;
                idx_nx_s   = 6'd0;
                m_nx_s     = 3'd0;
                acc_nx_s   = '0;
            end
        endcase
    end

    // Control state and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= LOAD;
            idx_r        <= 6'd0;
            m_r          <= 3'd0;
            acc_r        <= '0;
            coef_ready_r <= 1'b1;
            pix_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            pix_data_r   <= 8'd0;
        end else begin
            state_r      <= state_nx_s;
            idx_r        <= idx_nx_s;
            m_r          <= m_nx_s;
            acc_r        <= acc_nx_s;
            coef_ready_r <= (state_nx_s == LOAD);
            pix_valid_r  <= (state_nx_s == OUT);
            busy_r       <= (state_nx_s != LOAD);
            if (state_nx_s == OUT) begin
                pix_data_r <= pbuf_r[idx_nx_s];
            end
        end
    end

    // Block buffers; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (cbuf_we_s) begin
            cbuf_r[idx_r] <= coef_data;
        end
        if (tbuf_we_s) begin
            tbuf_r[idx_r] <= tmp_sat_s;
        end
        if (pbuf_we_s) begin
            pbuf_r[idx_r] <= pix_s;
        end
    end

    assign coef_ready = coef_ready_r;
    assign pix_valid  = pix_valid_r;
    assign busy       = busy_r;
    assign pix_data   = pix_data_r;

endmodule

// File: doc/idct_8x8_core.md
# idct_8x8_core

Sequential 8x8 two-dimensional inverse DCT; it reconstructs pixels from the coefficient blocks produced by the forward DCT path. It accepts 64 coefficients in raster order and computes a separable row pass and then a column pass on one shared multiply-accumulate unit. It then streams 64 pixels out over a valid/ready interface. It sits between the coefficient dequantiser and the frame writer in the decode path.

## Interface
- COEF_W, 12: signed coefficient width.
- TMP_W, 16: signed width of the intermediate row-pass result.
- ACC_W, 32: signed accumulator width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- coef_valid  in  1  coefficient beat is valid.
- coef_ready  out  1  core accepts a coefficient; high only in LOAD.
- coef_data  in  COEF_W  signed X[k1][k2], raster order: k1 is the row, k2 the column, row-major.
- pix_valid  out  1  pixel beat is valid; high only in OUT.
- pix_ready  in  1  downstream accepts the pixel.
- pix_data  out  8  pixel y[n1][n2], raster order: n1 is the row.
- busy  out  1  high in ROWS, COLS and OUT.

## Operation
- States: LOAD, ROWS, COLS, OUT. Reset state is LOAD.
- LOAD:
  - coef_ready=1.
  - Each beat where coef_valid&&coef_ready writes cbuf[idx] and increments the 6-bit idx.
  - The 64th accepted beat (idx 63) goes to ROWS with idx=0 and m=0.
- Cosine term C[k][n] = round(256 * a(k) * cos((2n+1)k*pi/16)), with a(0)=sqrt(1/8) and a(k>0)=1/2. Values are signed 9-bit plus sign, Q.8; for example C[0][n]=91 and C[1][0]=126.
- ROWS: computes tmp[k1][n2] = sum over m=k2 of X[k1][m]*C[m][n2].
  - One product per cycle, m=0..7; idx={k1,n2}.
  - On m=7, write the rounded result (acc+128)>>>8 into tbuf[idx], clear acc, and increment idx.
  - After idx 63 completes, go to COLS.
- COLS: computes y[n1][n2] = sum over m=k1 of C[m][n1]*tmp[m][n2].
  - Same schedule; idx={n1,n2}.
  - The result is rounded identically, then post-processed (see Configuration) into pbuf[idx].
  - After idx 63 completes, go to OUT.
- OUT:
  - pix_valid=1 and pix_data=pbuf[idx].
  - idx advances only on pix_valid&&pix_ready.
  - After the 64th transfer, go to LOAD.
- Arithmetic:
  - Products are sign-extended to ACC_W.
  - Rounding is an add of 128 followed by an arithmetic shift right of 8, i.e. round half up.
  - tmp is saturated to TMP_W; this is unreachable for legal inputs but required.
- Handshakes:
  - pix_data must stay stable while pix_valid && !pix_ready.
  - coef_valid is ignored outside LOAD.
- Reset mid-operation: returns to LOAD with idx=0 and acc=0, and discards the partial block. Buffer contents need not be cleared.

## Timing
- Reset values: coef_ready=1, pix_valid=0, busy=0, pix_data=0.
- ROWS takes exactly 512 cycles and COLS exactly 512 cycles.
- Take edge 0 as the edge that accepts the 64th coefficient. busy rises after edge 0, and pix_valid first rises after edge 1024.
- Minimum block period is 64+1024+64 = 1152 cycles.
- coef_ready rises in the cycle after the final pixel transfer.
- No overlap between blocks; throughput is one block per ≥1152 cycles.

## Configuration
- Macro: IDCT_LEVEL_SHIFT_EN.
- Defined: the output is y+128 clamped to [0,255], unsigned.
- Undefined: the output is y clamped to [-128,127], two's complement.
- Timing is identical in both builds.

## Structure
- Package idct_pkg:
  - state enum idct_state_t {LOAD, ROWS, COLS, OUT}.
  - COS_FRAC=8, ROUND_BIAS=128, BLK_N=8, BLK_SZ=64.
  - clamp limits for both output modes.
- Sub-module idct_cos_lut:
  - combinational; inputs k[2:0] and n[2:0]; output signed 10-bit C[k][n].
  - The core instantiates it once. Its k/n select is muxed by state: ROWS uses (m, n2) and COLS uses (m, n1).
- Storage:
  - cbuf: 64×COEF_W.
  - tbuf: 64×TMP_W.
  - pbuf: 64×8.

## Test plan
- All-zero block: output is 64 pixels of 0, or 128 with IDCT_LEVEL_SHIFT_EN.
- DC-only block, X[0][0]=64, rest 0: tmp row 0 is 23 and every pixel is 8 (136 with shift).
- Positive saturation, X[0][0]=1024: tmp is 364 and y is 129. Output is 127 without shift, 255 with shift.
- Negative saturation, X[0][0]=-1024: tmp is -364 and y is -129. Output is -128 without shift, 0 with shift.
- Backpressure on the DC-only block: hold pix_ready=0 for 10 cycles at pixel 5. pix_data stays stable, and exactly 64 transfers occur.
- Reset pulse in mid-COLS, then a fresh DC-64 block: busy drops immediately and coef_ready=1. The new block yields 8 on every pixel, with first pix_valid after edge 1024.
